hsid_metric_main: RTL and testbench
===================================

HSID_METRIC_MAIN -- requirements
Module: hsid_metric_main

Interface
REQ-001 SHALL have parameters: WORD_WIDTH, 32, input word width; DATA_WIDTH, 16, signed sample width; PACK, 2, samples per word (WORD_WIDTH >= PACK*DATA_WIDTH); HSI_BANDS, 128, max bands; HSI_LIBRARY_SIZE, 256, max library vectors; DATA_WIDTH_ACC, 48, accumulator width.
REQ-002 SHALL have ports: clk in 1 clock; rst_n in 1 asynchronous active-low reset; one clock domain.
REQ-003 SHALL have ports: hsi_vctr_in_valid in 1 word valid; hsi_vctr_in in WORD_WIDTH packed samples; hsi_bands_in in clog2(HSI_BANDS) band count; library_size_in in clog2(HSI_LIBRARY_SIZE) vector count; mode_in in 1 metric select (0 = squared error, 1 = absolute error).
REQ-004 SHALL have ports: start in 1; clear in 1; ready out 1; idle out 1; done out 1.
REQ-005 SHALL have ports: metric_min_value, metric_max_value out WORD_WIDTH; metric_min_ref, metric_max_ref out clog2(HSI_LIBRARY_SIZE); metric_out_valid out 1; metric_out out WORD_WIDTH; metric_out_ref out clog2(HSI_LIBRARY_SIZE).

Function
REQ-006 Lane k (bits k*DATA_WIDTH +: DATA_WIDTH) of word w SHALL carry band w*PACK+k; words per vector = ceil(hsi_bands_in/PACK); lanes with band >= hsi_bands_in ignored.
REQ-007 FSM states SHALL be IDLE, READ_CAPTURED, READ_LIBRARY, DRAIN, DONE.
REQ-008 IDLE & start SHALL latch hsi_bands_in, library_size_in, mode_in and enter READ_CAPTURED next cycle; start outside IDLE ignored.
REQ-009 ready SHALL be 1 exactly in READ_CAPTURED and READ_LIBRARY; a word is accepted on valid & ready; valid while ready=0 ignored.
REQ-010 Captured words SHALL be stored in an internal HSI_BANDS-sample buffer; after the last captured word is accepted, state moves to READ_LIBRARY with no ready gap.
REQ-011 Per library word: per-lane diff = lib - captured (DATA_WIDTH+1 signed); term = diff^2 (mode 0) or |diff| (mode 1); lane terms summed and added to a DATA_WIDTH_ACC accumulator cleared at each vector start.
REQ-012 Vector metric = accumulator, unnormalised, saturated to 2^WORD_WIDTH-1.
REQ-013 metric_out_valid SHALL pulse 1 cycle, exactly 2 cycles after acceptance of each vector's last word, with metric_out and metric_out_ref = vector index (0-based).
REQ-014 On metric_out_valid: vector 0 loads min and max; later vectors replace min only if strictly less, max only if strictly greater (ties keep lower ref); new values visible next cycle.
REQ-015 After the last library word is accepted state SHALL enter DRAIN (ready=0), then DONE the cycle after the final metric_out_valid; done=1 for one cycle in DONE, then IDLE.
REQ-016 idle SHALL be 1 only in IDLE; min/max outputs hold after done until clear or next start.
REQ-017 start SHALL zero min/max outputs and refs; library_size_in = 0 or hsi_bands_in = 0 SHALL go IDLE->DONE directly, no ready, outputs 0.
REQ-018 clear in any state SHALL zero min/max outputs, drop pipeline contents (no further metric_out_valid), return to IDLE next cycle; clear with start SHALL give clear priority.

Reset
REQ-019 rst_n low SHALL asynchronously force IDLE; ready=0, done=0, metric_out_valid=0, idle=1 after release; all values, refs, counters, accumulator 0.
REQ-020 rst_n asserted mid-run SHALL abandon the run; no done pulse follows release.

Structure
REQ-021 hsid_pkg SHALL hold default parameter constants, the metric mode enum, and the FSM state enum.
REQ-022 Per-word lane arithmetic (diff, square/abs, lane sum) SHALL be one sub-module, hsid_metric_lanes, parameterised by PACK, DATA_WIDTH, mode.

Verification
REQ-023 PACK=2, bands=4, lib=3, mode 0; captured [1,2,3,4]; lib [1,2,3,4],[0,0,0,0],[2,2,2,2] -> metric_out 0,30,6; min 0 ref 0, max 30 ref 1; done one cycle after third metric_out_valid.
REQ-024 Same vectors, mode 1 -> metric_out 0,10,4; min 0 ref 0, max 10 ref 1.
REQ-025 Three identical library vectors [5,5,5,5] vs captured [1,2,3,4] -> all metrics 30, min_ref 0, max_ref 0.
REQ-026 bands=4, captured all -32768, lib all 32767, mode 0 -> metric_out 0xFFFFFFFF (saturated).
REQ-027 clear during READ_LIBRARY of vector 1 -> idle=1 next cycle, outputs 0, no metric_out_valid, no done; library_size_in=0 start -> done next cycle, ready never 1.
REQ-028 rst_n pulsed in DRAIN -> idle=1, done never asserted, all outputs 0.

Source files
------------

// File: rtl/hsid_pkg.sv
// hsid_pkg: default sizes, metric mode and FSM state types
// shared by the hyperspectral distance metric engine.
package hsid_pkg;

  localparam int WORD_WIDTH_D       = 32;
  localparam int DATA_WIDTH_D       = 16;
  localparam int PACK_D             = 2;
  localparam int HSI_BANDS_D        = 128;
  localparam int HSI_LIBRARY_SIZE_D = 256;
  localparam int DATA_WIDTH_ACC_D   = 48;

  typedef enum logic {
    MODE_SQ  = 1'b0,
    MODE_ABS = 1'b1
  } metric_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    READ_CAPTURED,
    READ_LIBRARY,
    DRAIN,
    DONE
  } state_e;

  function automatic int words_for(input int bands, input int pack);
    return (bands + pack - 1) / pack;
  endfunction

endpackage

// File: rtl/hsid_metric_lanes.sv
// hsid_metric_lanes: per-word lane arithmetic (lib - captured, squared or abs, summed).
// Ports: i_lib/i_cap packed lanes, i_en lane mask, i_mode metric select, o_sum lane sum.
module hsid_metric_lanes
  import hsid_pkg::*;
#(
  parameter int PACK       = PACK_D,
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int SUM_W      = DATA_WIDTH_ACC_D
) (
  input  logic [PACK*DATA_WIDTH-1:0] i_lib,
  input  logic [PACK*DATA_WIDTH-1:0] i_cap,
  input  logic [PACK-1:0]            i_en,
  input  logic                       i_mode,
  output logic [SUM_W-1:0]           o_sum
);

  localparam int TW = 2 * DATA_WIDTH + 2;

  logic signed [DATA_WIDTH:0] w_diff;
  logic signed [TW-1:0]       w_dx;
  logic signed [TW-1:0]       w_sq;
  logic signed [TW-1:0]       w_abs;

  always_comb begin
    o_sum  = '0;
    w_diff = '0;
    w_dx   = '0;
    w_sq   = '0;
    w_abs  = '0;
    for (int k = 0; k < PACK; k++) begin
      w_diff = $signed({i_lib[k*DATA_WIDTH+DATA_WIDTH-1],
                        i_lib[k*DATA_WIDTH +: DATA_WIDTH]})
             - $signed({i_cap[k*DATA_WIDTH+DATA_WIDTH-1],
                        i_cap[k*DATA_WIDTH +: DATA_WIDTH]});
      w_dx  = TW'(w_diff);
      w_sq  = w_dx * w_dx;
      w_abs = (w_dx < 0) ? -w_dx : w_dx;
      if (i_en[k]) begin
        if (metric_mode_e'(i_mode) == MODE_ABS)
          o_sum = o_sum + SUM_W'(w_abs);
        else
          o_sum = o_sum + SUM_W'(w_sq);
      end
    end
  end

endmodule

// File: rtl/hsid_metric_main.sv
// hsid_metric_main: captures one spectrum, streams library vectors, emits a
// per-vector distance metric and tracks min/max. Ports: start/clear control,
// valid/ready word input, ready/idle/done status, metric stream and min/max.
module hsid_metric_main
  import hsid_pkg::*;
#(
  parameter int WORD_WIDTH       = WORD_WIDTH_D,
  parameter int DATA_WIDTH       = DATA_WIDTH_D,
  parameter int PACK             = PACK_D,
  parameter int HSI_BANDS        = HSI_BANDS_D,
  parameter int HSI_LIBRARY_SIZE = HSI_LIBRARY_SIZE_D,
  parameter int DATA_WIDTH_ACC   = DATA_WIDTH_ACC_D
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                hsi_vctr_in_valid,
  input  logic [WORD_WIDTH-1:0]               hsi_vctr_in,
  input  logic [$clog2(HSI_BANDS)-1:0]        hsi_bands_in,
  input  logic [$clog2(HSI_LIBRARY_SIZE)-1:0] library_size_in,
  input  logic                                mode_in,
  input  logic                                start,
  input  logic                                clear,
  output logic                                ready,
  output logic                                idle,
  output logic                                done,
  output logic [WORD_WIDTH-1:0]               metric_min_value,
  output logic [WORD_WIDTH-1:0]               metric_max_value,
  output logic [$clog2(HSI_LIBRARY_SIZE)-1:0] metric_min_ref,
  output logic [$clog2(HSI_LIBRARY_SIZE)-1:0] metric_max_ref,
  output logic                                metric_out_valid,
  output logic [WORD_WIDTH-1:0]               metric_out,
  output logic [$clog2(HSI_LIBRARY_SIZE)-1:0] metric_out_ref
);

  localparam int BW     = $clog2(HSI_BANDS);
  localparam int LW     = $clog2(HSI_LIBRARY_SIZE);
  localparam int LANE_W = PACK * DATA_WIDTH;
  localparam int WORDS  = (HSI_BANDS + PACK - 1) / PACK;
  localparam int WIDX   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int ACC_W  = DATA_WIDTH_ACC;

  state_e r_state;
  state_e w_next;

  logic [BW-1:0]     r_bands;
  logic [LW-1:0]     r_lib;
  logic              r_mode;
  logic [WIDX:0]     r_words;
  logic [WIDX-1:0]   r_word_cnt;
  logic [LW-1:0]     r_vec_cnt;
  logic [LANE_W-1:0] r_buf [WORDS];

  logic              w_ready;
  logic              w_accept;
  logic              w_start;
  logic              w_bypass;
  logic              w_last_word;
  logic              w_last_vec;
  logic              w_final_out;
  logic [WIDX:0]     w_words_in;
  logic [PACK-1:0]   w_lane_en;
  logic [ACC_W-1:0]  w_lane_sum;
  logic [ACC_W-1:0]  w_acc_next;
  logic [WORD_WIDTH-1:0] w_sat;

  logic              r_s1_valid;
  logic              r_s1_first;
  logic              r_s1_last;
  logic [LW-1:0]     r_s1_ref;
  logic [ACC_W-1:0]  r_s1_sum;
  logic [ACC_W-1:0]  r_acc;

  logic                  r_out_valid;
  logic [WORD_WIDTH-1:0] r_out;
  logic [LW-1:0]         r_out_ref;
  logic [WORD_WIDTH-1:0] r_min;
  logic [WORD_WIDTH-1:0] r_max;
  logic [LW-1:0]         r_min_ref;
  logic [LW-1:0]         r_max_ref;

  assign w_ready  = (r_state == READ_CAPTURED) ||
                    (r_state == READ_LIBRARY);
  assign w_accept = hsi_vctr_in_valid && w_ready;
  assign w_start  = (r_state == IDLE) && start && !clear;
  assign w_bypass = (hsi_bands_in == '0) ||
                    (library_size_in == '0);
  assign w_words_in =
    (WIDX+1)'(words_for(int'(hsi_bands_in), PACK));

  assign w_last_word =
    (int'(r_word_cnt) + 1 == int'(r_words));
  assign w_last_vec =
    (int'(r_vec_cnt) + 1 == int'(r_lib));
  // Last vector's metric leaving the pipe ends the drain.
  assign w_final_out = r_out_valid &&
    (int'(r_out_ref) + 1 == int'(r_lib));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (w_start)
          w_next = w_bypass ? DONE : READ_CAPTURED;
      READ_CAPTURED:
        if (w_accept && w_last_word)
          w_next = READ_LIBRARY;
      READ_LIBRARY:
        if (w_accept && w_last_word && w_last_vec)
          w_next = DRAIN;
      DRAIN:
        if (w_final_out) w_next = DONE;
      DONE:
        w_next = IDLE;
      default:
        w_next = IDLE;
    endcase
    if (clear) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bands    <= '0;
      r_lib      <= '0;
      r_mode     <= 1'b0;
      r_words    <= '0;
      r_word_cnt <= '0;
      r_vec_cnt  <= '0;
    end else if (clear) begin
      r_word_cnt <= '0;
      r_vec_cnt  <= '0;
    end else if (w_start) begin
      r_bands    <= hsi_bands_in;
      r_lib      <= library_size_in;
      r_mode     <= mode_in;
      r_words    <= w_words_in;
      r_word_cnt <= '0;
      r_vec_cnt  <= '0;
    end else if (w_accept) begin
      if (w_last_word) begin
        r_word_cnt <= '0;
        if (r_state == READ_LIBRARY)
          r_vec_cnt <= r_vec_cnt + 1'b1;
      end else begin
        r_word_cnt <= r_word_cnt + 1'b1;
      end
    end
  end

  // Captured spectrum store; never read before it is written.
  always_ff @(posedge clk) begin
    if (w_accept && (r_state == READ_CAPTURED))
      r_buf[r_word_cnt] <= hsi_vctr_in[LANE_W-1:0];
  end

  // Lanes past the band count in the final word carry padding.
  always_comb begin
    w_lane_en = '0;
    for (int k = 0; k < PACK; k++)
      w_lane_en[k] =
        (int'(r_word_cnt) * PACK + k) < int'(r_bands);
  end

  hsid_metric_lanes #(
    .PACK       (PACK),
    .DATA_WIDTH (DATA_WIDTH),
    .SUM_W      (ACC_W)
  ) u_lanes (
    .i_lib  (hsi_vctr_in[LANE_W-1:0]),
    .i_cap  (r_buf[r_word_cnt]),
    .i_en   (w_lane_en),
    .i_mode (r_mode),
    .o_sum  (w_lane_sum)
  );

  assign w_acc_next =
    (r_s1_first ? '0 : r_acc) + r_s1_sum;
  assign w_sat = (|w_acc_next[ACC_W-1:WORD_WIDTH])
               ? '1 : w_acc_next[WORD_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_ref    <= '0;
      r_s1_sum    <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_ref   <= '0;
    end else begin
      r_s1_valid  <= w_accept && !clear &&
                     (r_state == READ_LIBRARY);
      r_s1_first  <= (r_word_cnt == '0);
      r_s1_last   <= w_last_word;
      r_s1_ref    <= r_vec_cnt;
      r_s1_sum    <= w_lane_sum;
      r_out_valid <= 1'b0;
      if (clear || w_start) begin
        r_acc     <= '0;
        r_out     <= '0;
        r_out_ref <= '0;
      end else if (r_s1_valid) begin
        r_acc <= w_acc_next;
        if (r_s1_last) begin
          r_out_valid <= 1'b1;
          r_out       <= w_sat;
          r_out_ref   <= r_s1_ref;
        end
      end
    end
  end

  // Strict compares keep the lower index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min     <= '0;
      r_max     <= '0;
      r_min_ref <= '0;
      r_max_ref <= '0;
    end else if (clear || w_start) begin
      r_min     <= '0;
      r_max     <= '0;
      r_min_ref <= '0;
      r_max_ref <= '0;
    end else if (r_out_valid) begin
      if (r_out_ref == '0) begin
        r_min     <= r_out;
        r_max     <= r_out;
        r_min_ref <= r_out_ref;
        r_max_ref <= r_out_ref;
      end else begin
        if (r_out < r_min) begin
          r_min     <= r_out;
          r_min_ref <= r_out_ref;
        end
        if (r_out > r_max) begin
          r_max     <= r_out;
          r_max_ref <= r_out_ref;
        end
      end
    end
  end

  assign ready            = w_ready;
  assign idle             = (r_state == IDLE);
  assign done             = (r_state == DONE);
  assign metric_out_valid = r_out_valid;
  assign metric_out       = r_out;
  assign metric_out_ref   = r_out_ref;
  assign metric_min_value = r_min;
  assign metric_max_value = r_max;
  assign metric_min_ref   = r_min_ref;
  assign metric_max_ref   = r_max_ref;

endmodule

// File: tb/tb_hsid_metric_main.sv
// tb_hsid_metric_main: randomized and directed bench with a spectral
// distance model, per-cycle metric/done checker and min/max checks.
module tb_hsid_metric_main;

  localparam int WW = 32;
  localparam int DW = 16;
  localparam int PK = 2;
  localparam int NB = 128;
  localparam int NL = 256;
  localparam int AW = 48;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsi_vctr_in_valid = 1'b0;
  logic [31:0] hsi_vctr_in = '0;
  logic [6:0]  hsi_bands_in = '0;
  logic [7:0]  library_size_in = '0;
  logic        mode_in = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        ready, idle, done;
  logic [31:0] metric_min_value, metric_max_value;
  logic [7:0]  metric_min_ref, metric_max_ref;
  logic        metric_out_valid;
  logic [31:0] metric_out;
  logic [7:0]  metric_out_ref;

  always #5 clk = ~clk;

  hsid_metric_main #(
    .WORD_WIDTH(WW), .DATA_WIDTH(DW), .PACK(PK),
    .HSI_BANDS(NB), .HSI_LIBRARY_SIZE(NL),
    .DATA_WIDTH_ACC(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .hsi_vctr_in_valid(hsi_vctr_in_valid),
    .hsi_vctr_in(hsi_vctr_in),
    .hsi_bands_in(hsi_bands_in),
    .library_size_in(library_size_in),
    .mode_in(mode_in),
    .start(start), .clear(clear),
    .ready(ready), .idle(idle), .done(done),
    .metric_min_value(metric_min_value),
    .metric_max_value(metric_max_value),
    .metric_min_ref(metric_min_ref),
    .metric_max_ref(metric_max_ref),
    .metric_out_valid(metric_out_valid),
    .metric_out(metric_out),
    .metric_out_ref(metric_out_ref)
  );

  int total = 0;
  int bad = 0;
  int cap [NB];
  int libs [NL][NB];
  int t_bands = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic longint model_metric(input int v,
      input int bands, input logic mode);
    longint s = 0;
    longint d;
    for (int b = 0; b < bands; b++) begin
      d = longint'(libs[v][b]) - longint'(cap[b]);
      if (mode) s += (d < 0) ? -d : d;
      else      s += d * d;
    end
    return (s > 64'hFFFFFFFF) ? 64'hFFFFFFFF : s;
  endfunction

  function automatic logic [31:0] pack_word(input int v,
                                            input int w);
    logic [31:0] r;
    int val;
    int band;
    r = '0;
    for (int k = 0; k < PK; k++) begin
      band = w * PK + k;
      if (band < t_bands) val = (v < 0) ? cap[band] : libs[v][band];
      else                val = int'($urandom);
      r[k*DW +: DW] = val[15:0];
    end
    return r;
  endfunction

  // ---------------- checker ----------------
  typedef struct {
    int     due;
    longint val;
    int     rf;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   m_bands = 0, m_lib = 0, m_words = 1, acc_i = 0;
  logic m_mode = 1'b0;
  int   exp_done = -1;
  int   vv;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      exp_done = -1;
    end else begin
      if (metric_out_valid) begin
        if (q.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          e = q.pop_front();
          chk("valid_cycle", cyc, e.due);
          chk("metric_out", longint'(metric_out), e.val);
          chk("metric_out_ref", longint'(metric_out_ref), e.rf);
          if (e.rf == m_lib - 1) exp_done = cyc + 1;
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        chk("missing_valid", 0, 1);
        void'(q.pop_front());
      end
      if (done) begin
        chk("done_cycle", cyc, exp_done);
        exp_done = -1;
      end else if (exp_done != -1 && exp_done <= cyc) begin
        chk("missing_done", 0, 1);
        exp_done = -1;
      end
      if (clear) begin
        q.delete();
        exp_done = -1;
      end else begin
        if (start && idle) begin
          m_bands = int'(hsi_bands_in);
          m_lib   = int'(library_size_in);
          m_mode  = mode_in;
          m_words = (m_bands + PK - 1) / PK;
          acc_i   = 0;
          if (m_bands == 0 || m_lib == 0) exp_done = cyc + 1;
        end
        if (hsi_vctr_in_valid && ready) begin
          if (acc_i >= m_words &&
              ((acc_i - m_words) % m_words) == m_words - 1) begin
            vv = (acc_i - m_words) / m_words;
            q.push_back(exp_t'{cyc + 2,
              model_metric(vv, m_bands, m_mode), vv});
          end
          acc_i++;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int bands, input int lib,
                          input logic mode);
    hsi_bands_in    = 7'(bands);
    library_size_in = 8'(lib);
    mode_in         = mode;
    start           = 1'b1;
    tick();
    start           = 1'b0;
    hsi_bands_in    = 7'($urandom);
    library_size_in = 8'($urandom);
    mode_in         = 1'($urandom);
  endtask

  task automatic send(input logic [31:0] d, input bit gaps);
    bit got = 0;
    int g = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        start = ($urandom_range(0, 7) == 0);
        tick();
        start = 1'b0;
      end
    end
    hsi_vctr_in = d;
    hsi_vctr_in_valid = 1'b1;
    while (!got && g < 50) begin
      @(negedge clk);
      got = ready;
      tick();
      g++;
    end
    if (!got) chk("accept_timeout", 0, 1);
    hsi_vctr_in_valid = 1'b0;
    hsi_vctr_in = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    bit seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      seen = done;
      tick();
      n++;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic send_all(input int bands, input int lib,
                          input bit gaps);
    int w = (bands + PK - 1) / PK;
    for (int i = 0; i < w; i++) send(pack_word(-1, i), gaps);
    for (int v = 0; v < lib; v++)
      for (int i = 0; i < w; i++) send(pack_word(v, i), gaps);
  endtask

  task automatic run(input int bands, input int lib,
                     input logic mode, input bit gaps);
    t_bands = bands;
    do_start(bands, lib, mode);
    send_all(bands, lib, gaps);
    wait_done();
  endtask

  task automatic check_lit(input longint mn, input longint mr,
                           input longint mx, input longint xr);
    @(negedge clk);
    chk("idle_after_done", longint'(idle), 1);
    chk("min_value", longint'(metric_min_value), mn);
    chk("min_ref", longint'(metric_min_ref), mr);
    chk("max_value", longint'(metric_max_value), mx);
    chk("max_ref", longint'(metric_max_ref), xr);
    tick();
  endtask

  task automatic check_minmax(input int bands, input int lib,
                              input logic mode);
    longint mn, mx, m;
    int mr = 0, xr = 0;
    mn = model_metric(0, bands, mode);
    mx = mn;
    for (int v = 1; v < lib; v++) begin
      m = model_metric(v, bands, mode);
      if (m < mn) begin mn = m; mr = v; end
      if (m > mx) begin mx = m; xr = v; end
    end
    check_lit(mn, mr, mx, xr);
  endtask

  task automatic quiet(input string nm, input int n);
    bit seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (metric_out_valid || done || ready) seen = 1;
      tick();
    end
    chk(nm, longint'(seen), 0);
  endtask

  task automatic fill(input int bands, input int lib, input bit wide);
    logic signed [15:0] s;
    for (int b = 0; b < bands; b++) begin
      s = 16'($urandom);
      cap[b] = wide ? int'(s) : int'($urandom_range(0, 200)) - 100;
      for (int v = 0; v < lib; v++) begin
        s = 16'($urandom);
        libs[v][b] = wide ? int'(s)
                   : int'($urandom_range(0, 200)) - 100;
      end
    end
  endtask

  task automatic zeros_now(input string nm);
    chk({nm, "_min"}, longint'(metric_min_value), 0);
    chk({nm, "_max"}, longint'(metric_max_value), 0);
    chk({nm, "_minref"}, longint'(metric_min_ref), 0);
    chk({nm, "_maxref"}, longint'(metric_max_ref), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bands, lib;
    logic mode;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_idle", longint'(idle), 1);
    chk("rst_ready", longint'(ready), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_valid", longint'(metric_out_valid), 0);
    zeros_now("rst");
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("rel_idle", longint'(idle), 1);
    chk("rel_ready", longint'(ready), 0);
    tick();

    // squared / absolute error on the small reference set
    for (int b = 0; b < 4; b++) begin
      cap[b] = b + 1;
      libs[0][b] = b + 1;
      libs[1][b] = 0;
      libs[2][b] = 2;
    end
    chk("pin_sq_v1", model_metric(1, 4, 1'b0), 30);
    chk("pin_sq_v2", model_metric(2, 4, 1'b0), 6);
    chk("pin_abs_v2", model_metric(2, 4, 1'b1), 4);
    run(4, 3, 1'b0, 1'b0);
    check_lit(0, 0, 30, 1);
    run(4, 3, 1'b1, 1'b1);
    check_lit(0, 0, 10, 1);

    // identical library vectors keep ref 0
    for (int v = 0; v < 3; v++)
      for (int b = 0; b < 4; b++) libs[v][b] = 5;
    run(4, 3, 1'b0, 1'b0);
    check_lit(30, 0, 30, 0);

    // saturation
    for (int b = 0; b < 4; b++) begin
      cap[b] = -32768;
      libs[0][b] = 32767;
    end
    run(4, 1, 1'b0, 1'b0);
    check_lit(64'hFFFFFFFF, 0, 64'hFFFFFFFF, 0);

    // clear during vector 1 of the library
    fill(4, 3, 1'b0);
    t_bands = 4;
    do_start(4, 3, 1'b0);
    for (int i = 0; i < 2; i++) send(pack_word(-1, i), 1'b0);
    for (int i = 0; i < 2; i++) send(pack_word(0, i), 1'b0);
    send(pack_word(1, 0), 1'b0);
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("clr_idle", longint'(idle), 1);
    zeros_now("clr");
    tick();
    quiet("clr_quiet", 8);

    // zero library size and zero bands go straight to done
    do_start(4, 0, 1'b0);
    @(negedge clk);
    chk("bypass_lib_done", longint'(done), 1);
    chk("bypass_lib_ready", longint'(ready), 0);
    zeros_now("bypass_lib");
    tick();
    quiet("bypass_lib_quiet", 3);
    do_start(0, 5, 1'b1);
    @(negedge clk);
    chk("bypass_bands_done", longint'(done), 1);
    chk("bypass_bands_ready", longint'(ready), 0);
    tick();
    quiet("bypass_bands_quiet", 3);

    // reset asserted in drain
    fill(4, 3, 1'b0);
    t_bands = 4;
    do_start(4, 3, 1'b0);
    send_all(4, 3, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("drain_rst_idle", longint'(idle), 1);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("drain_rel_idle", longint'(idle), 1);
    chk("drain_rel_valid", longint'(metric_out_valid), 0);
    chk("drain_rel_out", longint'(metric_out), 0);
    zeros_now("drain_rel");
    tick();
    quiet("drain_quiet", 8);

    // randomized runs
    for (int r = 0; r < 24; r++) begin
      bands = $urandom_range(1, 20);
      lib   = $urandom_range(1, 6);
      mode  = 1'($urandom);
      fill(bands, lib, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) begin
        hsi_vctr_in_valid = 1'b1;
        hsi_vctr_in = $urandom;
        repeat (2) tick();
        hsi_vctr_in_valid = 1'b0;
      end
      run(bands, lib, mode, 1'b1);
      check_minmax(bands, lib, mode);
    end
    fill(127, 2, 1'b1);
    run(127, 2, 1'b0, 1'b0);
    check_minmax(127, 2, 1'b0);
    fill(127, 2, 1'b1);
    run(127, 2, 1'b1, 1'b1);
    check_minmax(127, 2, 1'b1);
    quiet("final_quiet", 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
